// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - opcodes, state encoding and IR field layout for the mini-CPU sequencer
package control_sequencer_pkg;

    localparam int OPC_W    = 5;
    localparam int NREG_DEF = 16;
    localparam int STATE_W  = 4;

    localparam logic [4:0] OPC_ADD  = 5'b00000;
    localparam logic [4:0] OPC_SUB  = 5'b00001;
    localparam logic [4:0] OPC_AND  = 5'b00010;
    localparam logic [4:0] OPC_OR   = 5'b00011;
    localparam logic [4:0] OPC_SHR  = 5'b00100;
    localparam logic [4:0] OPC_SHL  = 5'b00101;
    localparam logic [4:0] OPC_ROL  = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_MUL  = 5'b01000;
    localparam logic [4:0] OPC_DIV  = 5'b01001;
    localparam logic [4:0] OPC_NEG  = 5'b01010;
    localparam logic [4:0] OPC_NOT  = 5'b01011;
    localparam logic [4:0] OPC_NOP  = 5'b11110;
    localparam logic [4:0] OPC_HALT = 5'b11111;

    localparam logic [STATE_W-1:0] ST_RESET = 4'd0;
    localparam logic [STATE_W-1:0] ST_T0    = 4'd1;
    localparam logic [STATE_W-1:0] ST_T1    = 4'd2;
    localparam logic [STATE_W-1:0] ST_T2    = 4'd3;
    localparam logic [STATE_W-1:0] ST_T3    = 4'd4;
    localparam logic [STATE_W-1:0] ST_T4    = 4'd5;
    localparam logic [STATE_W-1:0] ST_T5    = 4'd6;
    localparam logic [STATE_W-1:0] ST_T6    = 4'd7;
    localparam logic [STATE_W-1:0] ST_HALT  = 4'd8;

    // IR[31:15] maps directly onto this struct: opc, Ra, Rb, Rc from MSB down
    localparam int IR_RC_LSB = 15;

    typedef struct packed {
        logic [4:0] opc;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } ir_fields_t;

    function automatic logic is_alu_op(input logic [4:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL,
            OPC_ROL, OPC_ROR, OPC_MUL, OPC_DIV, OPC_NEG, OPC_NOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] opc);
        return (opc == OPC_NEG) || (opc == OPC_NOT);
    endfunction

    function automatic logic is_wide(input logic [4:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// rtl/control_sequencer_reg_select_decoder.sv - 4-bit register index plus enable to one-hot select
module control_sequencer_reg_select_decoder #(
    parameter int NREG = 16
) (
    input  logic [3:0]      idx_i,
    input  logic            en_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0..T6 control unit producing every data_path strobe
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPW  = OPC_W,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ir_i,
    input  logic            mem_ready_i,
    input  logic            stop_i,
    output logic            pc_out_o,
    output logic            mdr_out_o,
    output logic            zhigh_out_o,
    output logic            zlow_out_o,
    output logic            hi_out_o,
    output logic            lo_out_o,
    output logic            mar_in_o,
    output logic            pc_in_o,
    output logic            inc_pc_o,
    output logic            read_o,
    output logic            mdr_in_o,
    output logic            ir_in_o,
    output logic            y_in_o,
    output logic            zhigh_in_o,
    output logic            zlow_in_o,
    output logic            hi_in_o,
    output logic            lo_in_o,
    output logic [NREG-1:0] r_out_o,
    output logic [NREG-1:0] r_in_o,
    output logic [OPW-1:0]  op_o,
    output logic            run_o,
    output logic            illegal_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               t1_first_q;
    ir_fields_t         fields_q;
    ir_fields_t         live;
    logic               unused_ir;
    logic               t3_alu;
    logic               rout_en, rin_en;
    logic [3:0]         rout_idx;

    // The IR register in data_path is only loaded at the end of T2, so T3 decodes it live
    // and freezes the fields for T4..T6.
    assign live      = ir_fields_t'(ir_i[31:IR_RC_LSB]);
    assign unused_ir = ^ir_i[IR_RC_LSB-1:0];
    assign t3_alu    = (state_q == ST_T3) && is_alu_op(live.opc);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = stop_i ? ST_HALT : ST_T1;
            ST_T1:    state_d = mem_ready_i ? ST_T2 : ST_T1;
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                if (live.opc == OPC_HALT)      state_d = ST_HALT;
                else if (is_alu_op(live.opc))  state_d = ST_T4;
                else                           state_d = ST_T0;
            end
            ST_T4:    state_d = ST_T5;
            ST_T5:    state_d = is_wide(fields_q.opc) ? ST_T6 : ST_T0;
            ST_T6:    state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            t1_first_q <= 1'b0;
            fields_q   <= '0;
        end else begin
            state_q    <= state_d;
            t1_first_q <= (state_q == ST_T0);
            if (state_q == ST_T3) begin
                fields_q <= live;
            end
        end
    end

    assign rout_en  = t3_alu || ((state_q == ST_T4) && !is_unary(fields_q.opc));
    assign rout_idx = (state_q == ST_T3) ? live.rb : fields_q.rc;
    assign rin_en   = (state_q == ST_T5) && !is_wide(fields_q.opc);

    control_sequencer_reg_select_decoder #(.NREG(NREG)) u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (r_out_o)
    );

    control_sequencer_reg_select_decoder #(.NREG(NREG)) u_rin_dec (
        .idx_i    (fields_q.ra),
        .en_i     (rin_en),
        .onehot_o (r_in_o)
    );

    always_comb begin
        pc_out_o    = 1'b0;
        mdr_out_o   = 1'b0;
        zhigh_out_o = 1'b0;
        zlow_out_o  = 1'b0;
        hi_out_o    = 1'b0;
        lo_out_o    = 1'b0;
        mar_in_o    = 1'b0;
        pc_in_o     = 1'b0;
        inc_pc_o    = 1'b0;
        read_o      = 1'b0;
        mdr_in_o    = 1'b0;
        ir_in_o     = 1'b0;
        y_in_o      = 1'b0;
        zhigh_in_o  = 1'b0;
        zlow_in_o   = 1'b0;
        hi_in_o     = 1'b0;
        lo_in_o     = 1'b0;
        op_o        = '0;
        illegal_o   = 1'b0;
        run_o       = (state_q != ST_RESET) && (state_q != ST_HALT);
        case (state_q)
            ST_T0: begin
                pc_out_o  = 1'b1;
                mar_in_o  = 1'b1;
                inc_pc_o  = 1'b1;
                zlow_in_o = 1'b1;
            end
            ST_T1: begin
                zlow_out_o = 1'b1;
                pc_in_o    = t1_first_q;
                read_o     = 1'b1;
                mdr_in_o   = 1'b1;
            end
            ST_T2: begin
                mdr_out_o = 1'b1;
                ir_in_o   = 1'b1;
            end
            ST_T3: begin
                y_in_o    = t3_alu;
                illegal_o = !is_alu_op(live.opc) && (live.opc != OPC_NOP) && (live.opc != OPC_HALT);
            end
            ST_T4: begin
                op_o       = OPW'(fields_q.opc);
                zhigh_in_o = 1'b1;
                zlow_in_o  = 1'b1;
            end
            ST_T5: begin
                zlow_out_o = 1'b1;
                lo_in_o    = is_wide(fields_q.opc);
            end
            ST_T6: begin
                zhigh_out_o = 1'b1;
                hi_in_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer with directed per-cycle vectors
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b1;
    logic        stop = 1'b0;
    logic        pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out;
    logic        mar_in, pc_in, inc_pc, read, mdr_in, ir_in, y_in;
    logic        zhigh_in, zlow_in, hi_in, lo_in, run, illegal;
    logic [15:0] r_out, r_in;
    logic [4:0]  op;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ir_i(ir), .mem_ready_i(mem_ready), .stop_i(stop),
        .pc_out_o(pc_out), .mdr_out_o(mdr_out), .zhigh_out_o(zhigh_out), .zlow_out_o(zlow_out),
        .hi_out_o(hi_out), .lo_out_o(lo_out), .mar_in_o(mar_in), .pc_in_o(pc_in),
        .inc_pc_o(inc_pc), .read_o(read), .mdr_in_o(mdr_in), .ir_in_o(ir_in), .y_in_o(y_in),
        .zhigh_in_o(zhigh_in), .zlow_in_o(zlow_in), .hi_in_o(hi_in), .lo_in_o(lo_in),
        .r_out_o(r_out), .r_in_o(r_in), .op_o(op), .run_o(run), .illegal_o(illegal)
    );

    localparam logic [16:0] PCOUT = 17'h00001, MDROUT = 17'h00002, ZHOUT = 17'h00004;
    localparam logic [16:0] ZLOUT = 17'h00008, MARIN = 17'h00040, PCIN = 17'h00080;
    localparam logic [16:0] INCPC = 17'h00100, READ = 17'h00200, MDRIN = 17'h00400;
    localparam logic [16:0] IRIN = 17'h00800, YIN = 17'h01000, ZHIN = 17'h02000;
    localparam logic [16:0] ZLIN = 17'h04000, HIIN = 17'h08000, LOIN = 17'h10000;

    typedef struct packed {
        logic [16:0] sb;
        logic [15:0] ro;
        logic [15:0] ri;
        logic [4:0]  op;
        logic        run;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic        rstn;
        logic [31:0] ir;
        logic        mr;
        logic        stop;
    } stim_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic exp_t mk(input logic [16:0] sb, input logic [15:0] ro, input logic [15:0] ri,
                                input logic [4:0] o, input logic rn, input logic il);
        exp_t e;
        e.sb = sb; e.ro = ro; e.ri = ri; e.op = o; e.run = rn; e.ill = il;
        return e;
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'b0};
    endfunction

    exp_t ZERO, T0, T1F, T1N, T2, T3D, T5W, T6;
    initial begin
        ZERO = mk(17'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        T0   = mk(PCOUT | MARIN | INCPC | ZLIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
        T1F  = mk(ZLOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
        T1N  = mk(ZLOUT | READ | MDRIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
        T2   = mk(MDROUT | IRIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
        T3D  = mk(17'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
        T5W  = mk(ZLOUT | LOIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
        T6   = mk(ZHOUT | HIIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    end

    function automatic exp_t t3(input logic [15:0] ro);
        return mk(YIN, ro, 16'h0, 5'h0, 1'b1, 1'b0);
    endfunction
    function automatic exp_t t4(input logic [15:0] ro, input logic [4:0] o);
        return mk(ZHIN | ZLIN, ro, 16'h0, o, 1'b1, 1'b0);
    endfunction
    function automatic exp_t t5(input logic [15:0] ri);
        return mk(ZLOUT, 16'h0, ri, 5'h0, 1'b1, 1'b0);
    endfunction

    task automatic step(input logic rstn, input logic [31:0] i, input logic mr, input logic st,
                        input exp_t e, input string nm);
        stim_t s;
        s.rstn = rstn; s.ir = i; s.mr = mr; s.stop = st;
        stim_q.push_back(s);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic restart(input logic [31:0] i);
        step(1'b0, i, 1'b1, 1'b0, ZERO, "reset");
        step(1'b1, i, 1'b1, 1'b0, ZERO, "release");
    endtask

    task automatic fetch(input logic [31:0] i);
        step(1'b1, i, 1'b1, 1'b0, T0,  "t0");
        step(1'b1, i, 1'b1, 1'b0, T1F, "t1");
        step(1'b1, i, 1'b1, 1'b0, T2,  "t2");
    endtask

    // Inputs for a cycle are applied just after the posedge that starts it.
    always @(posedge clk) begin
        #2;
        if (stim_q.size() != 0) begin
            stim_t s;
            s = stim_q.pop_front();
            rst_n     = s.rstn;
            ir        = s.ir;
            mem_ready = s.mr;
            stop      = s.stop;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e, a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.sb  = {lo_in, hi_in, zlow_in, zhigh_in, y_in, ir_in, mdr_in, read, inc_pc,
                     pc_in, mar_in, lo_out, hi_out, zlow_out, zhigh_out, mdr_out, pc_out};
            a.ro  = r_out;
            a.ri  = r_in;
            a.op  = op;
            a.run = run;
            a.ill = illegal;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got sb=%h rout=%h rin=%h op=%h run=%b ill=%b, want sb=%h rout=%h rin=%h op=%h run=%b ill=%b",
                         nm, $time, a.sb, a.ro, a.ri, a.op, a.run, a.ill,
                         e.sb, e.ro, e.ri, e.op, e.run, e.ill);
            end
        end
    end

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout: %0d entries left, want 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
            stim_q.delete();
        end
    endtask

    initial begin
        logic [31:0] i;

        // clear during T4 of ADD R1,R2,R3
        @(posedge clk); #1;
        i = enc(5'b00000, 4'd1, 4'd2, 4'd3);
        restart(i);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, t3(16'h0004), "add_t3");
        step(1'b0, i, 1'b1, 1'b0, ZERO, "clr_mid_t4");
        step(1'b1, i, 1'b1, 1'b0, ZERO, "clr_release");
        step(1'b1, i, 1'b1, 1'b0, T0,   "rec_t0");
        step(1'b1, i, 1'b1, 1'b0, T1F,  "rec_t1");
        drain("clear_mid");

        // ROL R1,R2,R3 then NEG R7,R8 then SUB R15,R15,R15 back to back
        @(posedge clk); #1;
        i = enc(5'b00110, 4'd1, 4'd2, 4'd3);
        restart(i);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, t3(16'h0004), "rol_t3");
        step(1'b1, i, 1'b1, 1'b0, t4(16'h0008, 5'b00110), "rol_t4");
        step(1'b1, i, 1'b1, 1'b0, t5(16'h0002), "rol_t5");
        i = enc(5'b01010, 4'd7, 4'd8, 4'd0);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, t3(16'h0100), "neg_t3");
        step(1'b1, i, 1'b1, 1'b0, t4(16'h0000, 5'b01010), "neg_t4");
        step(1'b1, i, 1'b1, 1'b0, t5(16'h0080), "neg_t5");
        i = enc(5'b00001, 4'd15, 4'd15, 4'd15);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, t3(16'h8000), "sub_t3");
        step(1'b1, i, 1'b1, 1'b0, t4(16'h8000, 5'b00001), "sub_t4");
        step(1'b1, i, 1'b1, 1'b0, t5(16'h8000), "sub_t5");
        step(1'b1, i, 1'b1, 1'b0, T0, "sub_next_t0");
        drain("alu_ops");

        // MUL R4,R5,R6 then NOP
        @(posedge clk); #1;
        i = enc(5'b01000, 4'd4, 4'd5, 4'd6);
        restart(i);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, t3(16'h0020), "mul_t3");
        step(1'b1, i, 1'b1, 1'b0, t4(16'h0040, 5'b01000), "mul_t4");
        step(1'b1, i, 1'b1, 1'b0, T5W, "mul_t5");
        step(1'b1, i, 1'b1, 1'b0, T6,  "mul_t6");
        i = enc(5'b11110, 4'd0, 4'd0, 4'd0);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, T3D, "nop_t3");
        step(1'b1, i, 1'b1, 1'b0, T0,  "nop_next_t0");
        drain("mul_nop");

        // memory wait: Mem_ready low for three T1 cycles
        @(posedge clk); #1;
        i = enc(5'b00000, 4'd1, 4'd2, 4'd3);
        restart(i);
        step(1'b1, i, 1'b0, 1'b0, T0,  "mw_t0");
        step(1'b1, i, 1'b0, 1'b0, T1F, "mw_t1_a");
        step(1'b1, i, 1'b0, 1'b0, T1N, "mw_t1_b");
        step(1'b1, i, 1'b0, 1'b0, T1N, "mw_t1_c");
        step(1'b1, i, 1'b1, 1'b0, T1N, "mw_t1_d");
        step(1'b1, i, 1'b1, 1'b0, T2,  "mw_t2");
        step(1'b1, i, 1'b1, 1'b0, t3(16'h0004), "mw_t3");
        drain("mem_wait");

        // undefined opcodes 01100 and 11101
        @(posedge clk); #1;
        i = enc(5'b01100, 4'd1, 4'd2, 4'd3);
        restart(i);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, mk(17'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1), "ill_t3");
        i = enc(5'b11101, 4'd1, 4'd2, 4'd3);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, mk(17'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1), "ill29_t3");
        step(1'b1, i, 1'b1, 1'b0, T0, "ill_next_t0");
        drain("illegal");

        // HALT opcode, then Stop in T0, then recovery by clear
        @(posedge clk); #1;
        i = enc(5'b11111, 4'd0, 4'd0, 4'd0);
        restart(i);
        fetch(i);
        step(1'b1, i, 1'b1, 1'b0, T3D, "halt_t3");
        for (int k = 0; k < 20; k++) step(1'b1, i, 1'b1, 1'b1, ZERO, "halt_opc_hold");
        i = enc(5'b00000, 4'd1, 4'd2, 4'd3);
        restart(i);
        step(1'b1, i, 1'b1, 1'b1, T0, "stop_t0");
        for (int k = 0; k < 20; k++) step(1'b1, i, 1'b1, 1'b0, ZERO, "stop_hold");
        restart(i);
        step(1'b1, i, 1'b1, 1'b0, T0,  "halt_rec_t0");
        step(1'b1, i, 1'b1, 1'b0, T1F, "halt_rec_t1");
        drain("halt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
